// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command-handshake bundle for uart_cmd_parser.
// slave: the parser itself; master: the UART receiver / SD FSM side.
interface uart_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  host_cmd;
    logic [5:0]  uart_cmd;
    logic [31:0] cmd_arg;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, host_cmd, uart_cmd, cmd_arg, frame_err, err_code, busy
    );

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, host_cmd, uart_cmd, cmd_arg, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/HOST/CMD/ARG3..ARG0[/CHK] UART frames into a held SD command.
// Define UART_CMD_CHECKSUM_EN to add the trailing XOR checksum byte and error code 10.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic              ex_clk,
    input  logic              reset,
    uart_cmd_parser_if.slave  io_bus
);

    localparam int unsigned   TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_CMD,
        S_ARG,
        S_CHK,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        E_NONE     = 2'b00,
        E_HEADER   = 2'b01,
        E_CHECKSUM = 2'b10,
        E_TIMEOUT  = 2'b11
    } err_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_host;
    logic [5:0]        r_cmd;
    logic [31:0]       r_arg;
    logic [1:0]        r_arg_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_frame_err;
    err_t              r_err_code;

    logic              w_ld_host;
    logic              w_ld_cmd;
    logic              w_ld_arg;
    logic              w_err;
    err_t              w_err_code;
    logic              w_timed;
    logic              w_timeout;
    logic [TO_W-1:0]   w_to_inc;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    assign w_timed   = (r_state inside {S_HOST, S_CMD, S_ARG, S_CHK});
    assign w_to_inc  = r_to_cnt + TO_W'(1);
    // The error fires on the idle cycle in which the counter would reach TIMEOUT_CYCLES-1.
    assign w_timeout = w_timed && !io_bus.rx_valid && (w_to_inc == TO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ex_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_ld_host    = 1'b0;
        w_ld_cmd     = 1'b0;
        w_ld_arg     = 1'b0;
        w_err        = 1'b0;
        w_err_code   = E_NONE;

        case (r_state)
            S_IDLE: begin
                if (io_bus.rx_valid && (io_bus.rx_data == SYNC_BYTE)) begin
                    w_next_state = S_HOST;
                end
            end

            S_HOST: begin
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data[7:4] == 4'h0) begin
                        w_ld_host    = 1'b1;
                        w_next_state = S_CMD;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = E_HEADER;
                        w_next_state = S_IDLE;
                    end
                end
            end

            S_CMD: begin
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data[7:6] == 2'b01) begin
                        w_ld_cmd     = 1'b1;
                        w_next_state = S_ARG;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = E_HEADER;
                        w_next_state = S_IDLE;
                    end
                end
            end

            S_ARG: begin
                if (io_bus.rx_valid) begin
                    w_ld_arg = 1'b1;
                    if (r_arg_cnt == 2'd3) begin
`ifdef UART_CMD_CHECKSUM_EN
                        w_next_state = S_CHK;
`else
                        w_next_state = S_HOLD;
`endif
                    end
                end
            end

            S_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data == r_chk) begin
                        w_next_state = S_HOLD;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = E_CHECKSUM;
                        w_next_state = S_IDLE;
                    end
                end
`else
                w_next_state = S_IDLE;
`endif
            end

            S_HOLD: begin
                // Any byte arriving here is dropped, even one coinciding with cmd_ready.
                if (io_bus.cmd_ready) begin
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_err        = 1'b1;
            w_err_code   = E_TIMEOUT;
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            r_host      <= '0;
            r_cmd       <= '0;
            r_arg       <= '0;
            r_arg_cnt   <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= E_NONE;
        end else begin
            r_frame_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end

            if (w_ld_host) begin
                r_host <= io_bus.rx_data[3:0];
            end
            if (w_ld_cmd) begin
                r_cmd <= io_bus.rx_data[5:0];
            end

            if (w_ld_cmd) begin
                r_arg_cnt <= '0;
            end else if (w_ld_arg) begin
                r_arg_cnt <= r_arg_cnt + 2'd1;
            end
            if (w_ld_arg) begin
                r_arg <= {r_arg[23:0], io_bus.rx_data};
            end

            if (w_timed && !io_bus.rx_valid && !w_timeout) begin
                r_to_cnt <= w_to_inc;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge ex_clk) begin
        if (reset) begin
            r_chk <= '0;
        end else if (r_state == S_IDLE) begin
            r_chk <= '0;
        end else if (w_ld_host || w_ld_cmd || w_ld_arg) begin
            r_chk <= r_chk ^ io_bus.rx_data;
        end
    end
`endif

    assign io_bus.cmd_valid = (r_state == S_HOLD);
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.host_cmd  = r_host;
    assign io_bus.uart_cmd  = r_cmd;
    assign io_bus.cmd_arg   = r_arg;
    assign io_bus.frame_err = r_frame_err;
    assign io_bus.err_code  = r_err_code;

    a_err_single: assert property (@(posedge ex_clk) disable iff (reset)
        r_frame_err |=> !r_frame_err);

    a_hold_stable: assert property (@(posedge ex_clk) disable iff (reset)
        (r_state == S_HOLD && !io_bus.cmd_ready) |=>
        (r_state == S_HOLD && $stable(r_host) && $stable(r_cmd) && $stable(r_arg)));

endmodule
